// File: rtl/countdown_pkg.sv
// Shared types and helpers for the BCD countdown timer.
package countdown_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOADED,
    RUNNING,
    PAUSED,
    EXPIRED
  } state_t;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;

  // Digits above 9 are not valid BCD; saturate them to 9.
  function automatic bcd_digit_t clamp_digit(input bcd_digit_t d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

  // Convert a three-digit BCD value to its binary number of seconds.
  function automatic int bcd_to_bin(input bcd_digit_t h, input bcd_digit_t t, input bcd_digit_t o);
    return int'(h) * 100 + int'(t) * 10 + int'(o);
  endfunction

endpackage

// File: rtl/bcd_countdown_timer_second_tick_gen.sv
// One-second prescaler: counts 0..TICK_DIV-1 while enabled and emits a
// one-cycle tick on the terminal count. The count is held while disabled.
module second_tick_gen #(
  parameter int TICK_DIV = 50000000
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] count;

  assign tick = enable && (count == LAST);

  // Prescaler counter: clear wins, otherwise advance and wrap while enabled.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      if (count == LAST) begin
        count <= '0;
      end else begin
        count <= count + CW'(1);
      end
    end
  end

endmodule

// File: rtl/bcd_countdown_timer.sv
// Three-digit BCD countdown timer: captures a time allotment on load, counts
// down once per second while run is high and flags expiry at 000.
// Optional feature macro: COUNTDOWN_WARN_EN adds the registered time_warn output.
module bcd_countdown_timer
  import countdown_pkg::*;
#(
  parameter int TICK_DIV  = 50000000,
  parameter int WARN_SECS = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic       run,
  input  logic [3:0] value_three,
  input  logic [3:0] value_two,
  input  logic [3:0] value_one,
  output logic [3:0] digit_three,
  output logic [3:0] digit_two,
  output logic [3:0] digit_one,
  output logic       running,
`ifdef COUNTDOWN_WARN_EN
  output logic       time_warn,
`endif
  output logic       time_up
);

  if (TICK_DIV < 1 || WARN_SECS < 0) begin : g_bad_params
    $error("bcd_countdown_timer: TICK_DIV must be >= 1 and WARN_SECS >= 0");
  end

  state_t     state_q, state_d;
  bcd_digit_t three_d, two_d, one_d;
  logic       up_d;
  logic       tick;
  logic       tick_en;
  logic       is_zero;

  // Count only in RUNNING with run held; a load in the same cycle suppresses it.
  assign tick_en = (state_q == RUNNING) && run && !load;
  assign is_zero = (digit_three == 4'd0) && (digit_two == 4'd0) && (digit_one == 4'd0);

  second_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clk   (clk),
    .reset (reset),
    .enable(tick_en),
    .clear (load),
    .tick  (tick)
  );

  // Next-state, BCD decrement and expiry decisions; load overrides everything.
  always_comb begin
    state_d = state_q;
    three_d = digit_three;
    two_d   = digit_two;
    one_d   = digit_one;
    up_d    = time_up;
    if (load) begin
      three_d = clamp_digit(value_three);
      two_d   = clamp_digit(value_two);
      one_d   = clamp_digit(value_one);
      if (three_d == 4'd0 && two_d == 4'd0 && one_d == 4'd0) begin
        state_d = EXPIRED;
        up_d    = 1'b1;
      end else begin
        state_d = LOADED;
        up_d    = 1'b0;
      end
    end else begin
      case (state_q)
        IDLE:    state_d = IDLE;
        LOADED:  if (run) state_d = RUNNING;
        RUNNING: begin
          if (!run) begin
            state_d = PAUSED;
          end else if (tick && !is_zero) begin
            if (digit_one != 4'd0) begin
              one_d = digit_one - 4'd1;
            end else begin
              one_d = BCD_MAX;
              if (digit_two != 4'd0) begin
                two_d = digit_two - 4'd1;
              end else begin
                two_d   = BCD_MAX;
                three_d = digit_three - 4'd1;
              end
            end
            if (three_d == 4'd0 && two_d == 4'd0 && one_d == 4'd0) begin
              state_d = EXPIRED;
              up_d    = 1'b1;
            end
          end
        end
        PAUSED:  if (run) state_d = RUNNING;
        EXPIRED: state_d = EXPIRED;
        default: state_d = IDLE;
      endcase
    end
  end

  // State, digit and flag registers; every output comes straight from a flop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      digit_three <= 4'd0;
      digit_two   <= 4'd0;
      digit_one   <= 4'd0;
      time_up     <= 1'b0;
      running     <= 1'b0;
    end else begin
      state_q     <= state_d;
      digit_three <= three_d;
      digit_two   <= two_d;
      digit_one   <= one_d;
      time_up     <= up_d;
      running     <= (state_d == RUNNING);
    end
  end

`ifdef COUNTDOWN_WARN_EN
  int next_secs;

  assign next_secs = bcd_to_bin(three_d, two_d, one_d);

  // Low-time warning while counting or paused with a nonzero remainder.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      time_warn <= 1'b0;
    end else begin
      time_warn <= ((state_d == RUNNING) || (state_d == PAUSED)) &&
                   (next_secs != 0) && (next_secs <= WARN_SECS);
    end
  end
`endif

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Self-checking bench for bcd_countdown_timer: a directed vector table, a few
// multi-cycle sequences and a randomized run against a seconds-level model.
module tb_bcd_countdown_timer;

  localparam int TICK_DIV  = 4;
  localparam int WARN_SECS = 10;

  localparam int M_IDLE  = 0;
  localparam int M_LOAD  = 1;
  localparam int M_RUN   = 2;
  localparam int M_PAUSE = 3;
  localparam int M_EXP   = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       load = 1'b0;
  logic       run = 1'b0;
  logic [3:0] value_three = 4'd0;
  logic [3:0] value_two = 4'd0;
  logic [3:0] value_one = 4'd0;
  logic [3:0] digit_three, digit_two, digit_one;
  logic       running, time_up;
`ifdef COUNTDOWN_WARN_EN
  logic       time_warn;
`endif

  int vectors = 0;
  int miscompares = 0;

  int m_secs = 0;
  int m_pre = 0;
  int m_mode = M_IDLE;
  bit m_up = 1'b0;

  typedef struct {
    logic        ld;
    logic        rn;
    logic [3:0]  v3;
    logic [3:0]  v2;
    logic [3:0]  v1;
    logic [11:0] exp_digits;
    logic        exp_run;
    logic        exp_up;
    logic        exp_warn;
  } vec_t;

  vec_t vecs[24];

  always #5 clk = ~clk;

  bcd_countdown_timer #(
    .TICK_DIV (TICK_DIV),
    .WARN_SECS(WARN_SECS)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .run        (run),
    .value_three(value_three),
    .value_two  (value_two),
    .value_one  (value_one),
    .digit_three(digit_three),
    .digit_two  (digit_two),
    .digit_one  (digit_one),
    .running    (running),
`ifdef COUNTDOWN_WARN_EN
    .time_warn  (time_warn),
`endif
    .time_up    (time_up)
  );

  function automatic vec_t mk(input logic ld, input logic rn, input logic [3:0] v3,
                              input logic [3:0] v2, input logic [3:0] v1,
                              input logic [11:0] d, input logic r, input logic u,
                              input logic w);
    vec_t v;
    v.ld = ld; v.rn = rn; v.v3 = v3; v.v2 = v2; v.v1 = v1;
    v.exp_digits = d; v.exp_run = r; v.exp_up = u; v.exp_warn = w;
    return v;
  endfunction

  function automatic int clampi(input logic [3:0] v);
    return (v > 4'd9) ? 9 : int'(v);
  endfunction

  function automatic logic [11:0] exp_bcd(input int s);
    return {4'(s / 100), 4'((s / 10) % 10), 4'(s % 10)};
  endfunction

  // Seconds-level reference model, advanced once per clock edge.
  task automatic model_step(input logic ld, input logic rn, input logic [3:0] v3,
                            input logic [3:0] v2, input logic [3:0] v1);
    if (ld) begin
      m_secs = clampi(v3) * 100 + clampi(v2) * 10 + clampi(v1);
      m_pre  = 0;
      m_up   = (m_secs == 0);
      m_mode = (m_secs == 0) ? M_EXP : M_LOAD;
    end else begin
      case (m_mode)
        M_LOAD:  if (rn) m_mode = M_RUN;
        M_RUN: begin
          if (!rn) begin
            m_mode = M_PAUSE;
          end else begin
            m_pre = m_pre + 1;
            if (m_pre == TICK_DIV) begin
              m_pre  = 0;
              m_secs = m_secs - 1;
              if (m_secs == 0) begin
                m_mode = M_EXP;
                m_up   = 1'b1;
              end
            end
          end
        end
        M_PAUSE: if (rn) m_mode = M_RUN;
        default: ;
      endcase
    end
  endtask

  task automatic model_reset();
    m_secs = 0;
    m_pre  = 0;
    m_mode = M_IDLE;
    m_up   = 1'b0;
  endtask

  task automatic check_val(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic apply_stimulus(input logic ld, input logic rn, input logic [3:0] v3,
                                input logic [3:0] v2, input logic [3:0] v1);
    @(negedge clk);
    load = ld; run = rn; value_three = v3; value_two = v2; value_one = v1;
    @(posedge clk);
    model_step(ld, rn, v3, v2, v1);
    #1;
  endtask

  task automatic check_output(input string tag);
    check_val({tag, "_digits"}, {20'd0, digit_three, digit_two, digit_one}, {20'd0, exp_bcd(m_secs)});
    check_val({tag, "_running"}, {31'd0, running}, {31'd0, (m_mode == M_RUN)});
    check_val({tag, "_time_up"}, {31'd0, time_up}, {31'd0, m_up});
`ifdef COUNTDOWN_WARN_EN
    check_val({tag, "_warn"}, {31'd0, time_warn},
              {31'd0, ((m_mode == M_RUN || m_mode == M_PAUSE) && m_secs > 0 && m_secs <= WARN_SECS)});
`endif
  endtask

  initial begin
    vecs[0]  = mk(1, 1, 2, 0, 0,   12'h200, 0, 0, 0);
    vecs[1]  = mk(0, 1, 0, 0, 0,   12'h200, 1, 0, 0);
    vecs[2]  = mk(0, 1, 0, 0, 0,   12'h200, 1, 0, 0);
    vecs[3]  = mk(0, 1, 0, 0, 0,   12'h200, 1, 0, 0);
    vecs[4]  = mk(0, 1, 0, 0, 0,   12'h200, 1, 0, 0);
    vecs[5]  = mk(0, 1, 0, 0, 0,   12'h199, 1, 0, 0);
    vecs[6]  = mk(0, 1, 0, 0, 0,   12'h199, 1, 0, 0);
    vecs[7]  = mk(0, 1, 0, 0, 0,   12'h199, 1, 0, 0);
    vecs[8]  = mk(0, 1, 0, 0, 0,   12'h199, 1, 0, 0);
    vecs[9]  = mk(0, 1, 0, 0, 0,   12'h198, 1, 0, 0);
    vecs[10] = mk(0, 1, 0, 0, 0,   12'h198, 1, 0, 0);
    vecs[11] = mk(0, 1, 0, 0, 0,   12'h198, 1, 0, 0);
    vecs[12] = mk(0, 1, 0, 0, 0,   12'h198, 1, 0, 0);
    vecs[13] = mk(1, 1, 0, 3, 12,  12'h039, 0, 0, 0);
    vecs[14] = mk(0, 0, 0, 0, 0,   12'h039, 0, 0, 0);
    vecs[15] = mk(1, 1, 0, 0, 0,   12'h000, 0, 1, 0);
    vecs[16] = mk(0, 1, 0, 0, 0,   12'h000, 0, 1, 0);
    vecs[17] = mk(1, 0, 0, 0, 5,   12'h005, 0, 0, 0);
    vecs[18] = mk(0, 1, 0, 0, 0,   12'h005, 1, 0, 1);
    vecs[19] = mk(0, 1, 0, 0, 0,   12'h005, 1, 0, 1);
    vecs[20] = mk(0, 1, 0, 0, 0,   12'h005, 1, 0, 1);
    vecs[21] = mk(0, 1, 0, 0, 0,   12'h005, 1, 0, 1);
    vecs[22] = mk(0, 1, 0, 0, 0,   12'h004, 1, 0, 1);
    vecs[23] = mk(1, 0, 15, 15, 15, 12'h999, 0, 0, 0);

    // Reset state.
    #1 reset = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_val("reset_digits", {20'd0, digit_three, digit_two, digit_one}, 32'h0);
    check_val("reset_running", {31'd0, running}, 32'h0);
    check_val("reset_time_up", {31'd0, time_up}, 32'h0);
    reset = 1'b1;

    // Directed vector table.
    for (int i = 0; i < 24; i++) begin
      apply_stimulus(vecs[i].ld, vecs[i].rn, vecs[i].v3, vecs[i].v2, vecs[i].v1);
      check_val($sformatf("vec%0d_digits", i), {20'd0, digit_three, digit_two, digit_one},
                {20'd0, vecs[i].exp_digits});
      check_val($sformatf("vec%0d_running", i), {31'd0, running}, {31'd0, vecs[i].exp_run});
      check_val($sformatf("vec%0d_time_up", i), {31'd0, time_up}, {31'd0, vecs[i].exp_up});
`ifdef COUNTDOWN_WARN_EN
      check_val($sformatf("vec%0d_warn", i), {31'd0, time_warn}, {31'd0, vecs[i].exp_warn});
`endif
    end

    // Count 010 down to expiry, then hold for 20 cycles with run high.
    begin
      int n = 0;
      apply_stimulus(1, 1, 0, 1, 0);
      check_output("seq010_load");
      while (time_up !== 1'b1 && n < 60) begin
        apply_stimulus(0, 1, 0, 0, 0);
        check_output("seq010_run");
        n++;
      end
      check_val("seq010_expiry_cycles", n, 41);
      check_val("seq010_expired_running", {31'd0, running}, 32'h0);
      for (int i = 0; i < 20; i++) begin
        apply_stimulus(0, 1, 0, 0, 0);
        check_output("seq010_hold");
      end
      check_val("seq010_hold_digits", {20'd0, digit_three, digit_two, digit_one}, 32'h0);
    end

    // Pause with the prescaler part-way, then resume.
    apply_stimulus(1, 1, 0, 2, 5);
    check_output("pause_load");
    for (int i = 0; i < 7; i++) begin
      apply_stimulus(0, 1, 0, 0, 0);
      check_output("pause_run");
    end
    for (int i = 0; i < 10; i++) begin
      apply_stimulus(0, 0, 0, 0, 0);
      check_output("pause_hold");
    end
    check_val("pause_frozen", {20'd0, digit_three, digit_two, digit_one}, 32'h024);
    apply_stimulus(0, 1, 0, 0, 0);
    check_output("pause_resume");
    apply_stimulus(0, 1, 0, 0, 0);
    check_val("pause_resume_1", {20'd0, digit_three, digit_two, digit_one}, 32'h024);
    apply_stimulus(0, 1, 0, 0, 0);
    check_val("pause_resume_2", {20'd0, digit_three, digit_two, digit_one}, 32'h023);

    // Warning window across 011 down to 000.
    apply_stimulus(1, 1, 0, 1, 1);
    check_output("warn_load");
    for (int i = 0; i < 50; i++) begin
      apply_stimulus(0, 1, 0, 0, 0);
      check_output("warn_run");
    end

    // Randomized load / run activity against the model.
    for (int i = 0; i < 600; i++) begin
      logic ld, rn;
      logic [3:0] v3, v2, v1;
      ld = ($urandom_range(0, 15) == 0);
      rn = ($urandom_range(0, 7) != 0);
      v3 = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
      v2 = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 1));
      v1 = 4'($urandom_range(0, 15));
      apply_stimulus(ld, rn, v3, v2, v1);
      check_output("rand");
    end

    // Asynchronous reset mid-count, away from any clock edge.
    apply_stimulus(1, 1, 0, 5, 0);
    for (int i = 0; i < 6; i++) apply_stimulus(0, 1, 0, 0, 0);
    check_output("areset_pre");
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    model_reset();
    check_val("areset_digits", {20'd0, digit_three, digit_two, digit_one}, 32'h0);
    check_val("areset_running", {31'd0, running}, 32'h0);
    check_val("areset_time_up", {31'd0, time_up}, 32'h0);
`ifdef COUNTDOWN_WARN_EN
    check_val("areset_warn", {31'd0, time_warn}, 32'h0);
`endif
    @(negedge clk);
    reset = 1'b1;
    apply_stimulus(0, 1, 0, 0, 0);
    check_output("areset_idle");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
